// File: rtl/cpu_datapath.sv
// Purpose: execution datapath of the one-cycle CPU (ACC, register file, data memory, ALU, Z/C flags).
// Latency: operand fetch, ALU and effective address are combinational; all state updates land on the next rising edge.
// Backpressure: none; one control word is consumed every clock and is always accepted.
module cpu_datapath #(
  parameter int WIDTH           = 8,
  parameter int ALU_INSTR_WIDTH = 4,
  parameter int REG_F_SEL_SIZE  = 4,
  parameter int IN_B_SEL_SIZE   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ALU_INSTR_WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0]           imm,
  input  logic [IN_B_SEL_SIZE-1:0]   in_b_sel,
  input  logic [REG_F_SEL_SIZE-1:0]  reg_f_sel,
  input  logic                       en_reg_f,
  input  logic [WIDTH-1:0]           d_mem_addr,
  input  logic                       d_mem_addr_mode,
  input  logic                       en_d_mem,
  input  logic                       en_acc,
  output logic                       z_flag,
  output logic                       c_flag,
  output logic [WIDTH-1:0]           acc_out
);

  localparam int REG_N = 1 << REG_F_SEL_SIZE;
  localparam int MEM_N = 1 << WIDTH;

  localparam logic [ALU_INSTR_WIDTH-1:0] OP_PASS_A = ALU_INSTR_WIDTH'(0);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_ADD    = ALU_INSTR_WIDTH'(1);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_SUB    = ALU_INSTR_WIDTH'(2);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_AND    = ALU_INSTR_WIDTH'(3);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_OR     = ALU_INSTR_WIDTH'(4);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_XOR    = ALU_INSTR_WIDTH'(5);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_NOT    = ALU_INSTR_WIDTH'(6);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_PASS_B = ALU_INSTR_WIDTH'(7);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_SHL    = ALU_INSTR_WIDTH'(8);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_SHR    = ALU_INSTR_WIDTH'(9);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_INC    = ALU_INSTR_WIDTH'(10);
  localparam logic [ALU_INSTR_WIDTH-1:0] OP_DEC    = ALU_INSTR_WIDTH'(11);

  localparam logic [IN_B_SEL_SIZE-1:0] B_IMM  = IN_B_SEL_SIZE'(0);
  localparam logic [IN_B_SEL_SIZE-1:0] B_REGF = IN_B_SEL_SIZE'(1);
  localparam logic [IN_B_SEL_SIZE-1:0] B_DMEM = IN_B_SEL_SIZE'(2);

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] acc_q;
  logic             z_q;
  logic             c_q;
  logic [WIDTH-1:0] reg_f [REG_N];
  logic [WIDTH-1:0] dmem  [MEM_N];

  logic [WIDTH-1:0] reg_rd;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_next;

  assign reg_rd  = reg_f[reg_f_sel];
  assign acc_out = acc_q;
  assign z_flag  = z_q;
  assign c_flag  = c_q;

  // Effective address: direct, or register base plus offset wrapping modulo 2^WIDTH.
  always_comb begin
    ea = d_mem_addr;
    if (d_mem_addr_mode) begin
      ea = reg_rd + d_mem_addr;
    end
  end

  // Operand-B source select; code 3 supplies zero.
  always_comb begin
    op_b = '0;
    case (in_b_sel)
      B_IMM:   op_b = imm;
      B_REGF:  op_b = reg_rd;
      B_DMEM:  op_b = dmem[ea];
      default: op_b = '0;
    endcase
  end

  // ALU: WIDTH-bit truncated result; carry only touched by arithmetic and shift ops.
  always_comb begin
    sum     = '0;
    alu_res = acc_q;
    c_next  = c_q;
    case (alu_out)
      OP_PASS_A: alu_res = acc_q;
      OP_ADD: begin
        sum     = {1'b0, acc_q} + {1'b0, op_b};
        alu_res = sum[WIDTH-1:0];
        c_next  = sum[WIDTH];
      end
      OP_SUB: begin
        // A wrapped-negative difference sets the extra bit, which is exactly the borrow.
        sum     = {1'b0, acc_q} - {1'b0, op_b};
        alu_res = sum[WIDTH-1:0];
        c_next  = sum[WIDTH];
      end
      OP_AND:    alu_res = acc_q & op_b;
      OP_OR:     alu_res = acc_q | op_b;
      OP_XOR:    alu_res = acc_q ^ op_b;
      OP_NOT:    alu_res = ~acc_q;
      OP_PASS_B: alu_res = op_b;
      OP_SHL: begin
        alu_res = {acc_q[WIDTH-2:0], 1'b0};
        c_next  = acc_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[WIDTH-1:1]};
        c_next  = acc_q[0];
      end
      OP_INC: begin
        sum     = {1'b0, acc_q} + ONE_EXT;
        alu_res = sum[WIDTH-1:0];
        c_next  = sum[WIDTH];
      end
      OP_DEC: begin
        sum     = {1'b0, acc_q} - ONE_EXT;
        alu_res = sum[WIDTH-1:0];
        c_next  = sum[WIDTH];
      end
      default:   alu_res = acc_q;
    endcase
  end

  // Accumulator and flags; reset leaves Z set to agree with a zero accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      z_q   <= 1'b1;
      c_q   <= 1'b0;
    end else if (en_acc) begin
      acc_q <= alu_res;
      z_q   <= (alu_res == '0);
      c_q   <= c_next;
    end
  end

  // Register file stores the pre-edge accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) begin
        reg_f[i] <= '0;
      end
    end else if (en_reg_f) begin
      reg_f[reg_f_sel] <= acc_q;
    end
  end

  // Data memory is never cleared; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && en_d_mem) begin
      dmem[ea] <= acc_q;
    end
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Execution datapath of the one-cycle CPU, directly downstream of the control unit. Consumes the decoded control word (ALU op, immediate, operand-B select, register-file select and write enable, data-memory address/mode/write enable, accumulator enable) and returns `z_flag` for conditional jumps. Contains the accumulator, a register file, a data memory, a combinational ALU and the Z/C flag registers. All state updates occur on one clock edge per instruction.

## Interface
- `WIDTH`, 8, data and data-memory address width
- `ALU_INSTR_WIDTH`, 4, ALU opcode width
- `REG_F_SEL_SIZE`, 4, register-file index width (2^4 = 16 registers)
- `IN_B_SEL_SIZE`, 2, operand-B select width
- `clk`  in  1  clock, all updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alu_out`  in  4  ALU opcode
- `imm`  in  WIDTH  immediate operand
- `in_b_sel`  in  2  operand-B source select
- `reg_f_sel`  in  4  register-file index
- `en_reg_f`  in  1  write accumulator into `reg_f[reg_f_sel]`
- `d_mem_addr`  in  WIDTH  data-memory address or offset
- `d_mem_addr_mode`  in  1  0 = direct, 1 = base+offset
- `en_d_mem`  in  1  write accumulator into data memory
- `en_acc`  in  1  load ALU result into accumulator and update flags
- `z_flag`  out  1  registered zero flag
- `c_flag`  out  1  registered carry/borrow flag
- `acc_out`  out  WIDTH  accumulator value

## Operation
- Effective address `ea`:
  - Mode 0: `ea = d_mem_addr`.
  - Mode 1: `ea = (reg_f[reg_f_sel] + d_mem_addr) mod 2^WIDTH`. Wraps; no carry is produced.
- Operand A is always ACC. Operand B by `in_b_sel`: 0 = `imm`, 1 = `reg_f[reg_f_sel]`, 2 = `dmem[ea]`, 3 = 0.
- ALU ops: 0 pass A, 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 pass B, 8 SHL A, 9 SHR A (logical), A INC A, B DEC A. Codes C–F = pass A.
- Result is WIDTH bits, truncated. Internally a WIDTH+1-bit sum feeds carry.
- Carry rules:
  - ADD/INC: carry-out.
  - SUB/DEC: borrow (1 when A < subtrahend).
  - SHL: old A[MSB].
  - SHR: old A[0].
  - All other ops leave C unchanged.
- `en_acc` = 1: ACC <= result; Z <= (result == 0); C updated per the carry rules.
- `en_acc` = 0: ACC, Z and C hold. The ALU output is ignored.
- `en_reg_f` = 1: `reg_f[reg_f_sel] <= ACC` (pre-edge value).
- `en_d_mem` = 1: `dmem[ea] <= ACC` (pre-edge value). `ea` is computed with the pre-edge register-file contents.
- Any combination of enables in the same cycle is legal. Every write uses pre-edge ACC and pre-edge register-file/memory contents. A register used as base in mode 1 and written in the same cycle supplies its old value.
- Data memory is 2^WIDTH words. Reads are combinational.

## Timing
- Reset (`rst` low, asynchronous, no clock needed):
  - ACC = 0, `acc_out` = 0.
  - `z_flag` = 1 (consistent with ACC = 0).
  - `c_flag` = 0.
  - All register-file entries = 0.
  - Data memory is not reset; contents are undefined until written.
- Reset asserted mid-instruction: the pending write is discarded. Reset deassertion is synchronous to `clk` by the system; the first edge after release executes normally.
- Latency:
  - Operand fetch, ALU and `ea` are combinational within the cycle.
  - ACC, flags, register-file and memory updates are visible one edge after the control word is presented.
  - `z_flag` seen by the control unit in cycle n reflects the last `en_acc` instruction at or before cycle n−1.
- No handshakes. One instruction per clock, always accepted.

## Test plan
- Reset then immediate ops:
  - Pulse `rst` low → `acc_out` = 0, `z_flag` = 1, `c_flag` = 0.
  - `imm` = 0x05, op 7, `in_b_sel` = 0, `en_acc` → `acc_out` = 0x05, Z = 0.
- Add with carry and zero:
  - ACC = 0xFF, ADD imm 0x01 → ACC = 0x00, Z = 1, C = 1.
  - Next cycle SUB imm 0x01 → ACC = 0xFF, Z = 0, C = 1 (borrow).
- Register-file path:
  - ACC = 0x3C, `en_reg_f`, `reg_f_sel` = 4.
  - Then ACC = 0x00.
  - Then op 4 (OR), `in_b_sel` = 1, sel 4 → ACC = 0x3C, register 15 still 0.
- Memory direct vs base+offset with wrap:
  - reg 2 = 0xF0. ACC = 0xAA, `en_d_mem`, mode 1, `d_mem_addr` = 0x20 → `dmem[0x10]` = 0xAA.
  - Read back in mode 0, address 0x10, op 7, `in_b_sel` = 2 → ACC = 0xAA.
- Simultaneous writes: ACC = 0x11, one cycle with `en_acc` (pass imm 0x22) + `en_reg_f` sel 1 + `en_d_mem` addr 0x05 → reg 1 = 0x11, `dmem[5]` = 0x11, ACC = 0x22.
- Shifts and async reset:
  - ACC = 0x81, SHL → ACC = 0x02, C = 1.
  - SHR → ACC = 0x01, C = 0.
  - Assert `rst` between edges → outputs return to reset values immediately; register file reads 0.
